// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - R-type function codes handled (or recognised) by the HI/LO unit
//   - sequencer state encoding
//   - operation kind carried through the iteration loop
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_kind_e;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One iteration of the unsigned multiply / divide loop (purely combinational).
//   op_i    : OP_MUL -> shift-add step, OP_DIV -> restoring-divide step
//   acc_i   : 2*WIDTH working register
//             multiply: {partial product, remaining multiplier bits}
//             divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o   : working register after this step
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_kind_e               op_i,
    input  logic [2*WIDTH-1:0]     acc_i,
    input  logic [WIDTH-1:0]       opnd_i,
    output logic [2*WIDTH-1:0]     acc_o
);

    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   mul_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       diff_s;
    logic [2*WIDTH-1:0]   div_s;

    // Compute both candidate next values and select by operation kind.
    always_comb begin
        // Multiply: add the multiplicand into the upper half when the current
        // multiplier bit is set, keeping the carry, then shift right by one.
        sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        if (acc_i[0]) begin
            mul_s = {sum_s, acc_i[WIDTH-1:1]};
        end else begin
            mul_s = {1'b0, acc_i[2*WIDTH-1:1]};
        end

        // Divide: shift the next dividend bit into the remainder and try to
        // subtract. The remainder stays below the divisor, so WIDTH+1 bits
        // are enough and the top bit of the difference is the borrow.
        rem_sh_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, opnd_i};
        if (!diff_s[WIDTH]) begin
            div_s = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            div_s = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end

        case (op_i)
            OP_MUL:  acc_o = mul_s;
            OP_DIV:  acc_o = div_s;
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// Accepts MULT/MULTU/DIV/DIVU (WIDTH iterations + one sign-fix cycle) and
// MTHI/MTLO (single-cycle write) by R-type function code.
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   start, func      : request valid and its function code
//   rs_val, rt_val   : operands (rs also carries MTHI/MTLO data)
//   flush            : abort in-flight operation / drop a new request
//   busy             : iterative operation in progress (registered)
//   stall            : start & busy (combinational)
//   done             : one-cycle pulse after MULT/DIV wrote HI/LO
//   hi, lo           : HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         func,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    input  logic               flush,
    output logic               busy,
    output logic               stall,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        neg_w = ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        neg_2w = ~x + ONE_2W;
    endfunction

    state_e               state_q, state_d;
    op_kind_e             op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 is_mul_s, is_div_s, is_signed_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic                 rt_zero_s;
    logic [2*WIDTH-1:0]   step_acc_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s;
    logic [WIDTH-1:0]     fix_hi_s, fix_lo_s;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc_s)
    );

    // Decode the request and take operand magnitudes for signed operations.
    always_comb begin
        is_mul_s    = (func == FN_MULT) || (func == FN_MULTU);
        is_div_s    = (func == FN_DIV)  || (func == FN_DIVU);
        is_signed_s = (func == FN_MULT) || (func == FN_DIV);
        a_neg_s     = is_signed_s & rs_val[WIDTH-1];
        b_neg_s     = is_signed_s & rt_val[WIDTH-1];
        rt_zero_s   = (rt_val == {WIDTH{1'b0}});
        if (a_neg_s) begin
            a_mag_s = neg_w(rs_val);
        end else begin
            a_mag_s = rs_val;
        end
        if (b_neg_s) begin
            b_mag_s = neg_w(rt_val);
        end else begin
            b_mag_s = rt_val;
        end
    end

    // Sign correction of the finished unsigned result (used in FIX).
    always_comb begin
        if (neg_res_q) begin
            prod_s = neg_2w(acc_q);
            quo_s  = neg_w(acc_q[WIDTH-1:0]);
        end else begin
            prod_s = acc_q;
            quo_s  = acc_q[WIDTH-1:0];
        end
        if (neg_rem_q) begin
            rem_s = neg_w(acc_q[2*WIDTH-1:WIDTH]);
        end else begin
            rem_s = acc_q[2*WIDTH-1:WIDTH];
        end
        if (op_q == OP_MUL) begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end
    end

    // Sequencer next-state logic: IDLE accepts, ITER steps, FIX commits.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (is_mul_s || is_div_s) begin
                        state_d   = ITER;
                        op_d      = is_div_s ? OP_DIV : OP_MUL;
                        cnt_d     = CNT_INIT;
                        acc_d     = {{WIDTH{1'b0}}, a_mag_s};
                        opnd_d    = b_mag_s;
                        // Divide by zero keeps an all-ones quotient, so the
                        // quotient is never negated in that case.
                        neg_res_d = (a_neg_s ^ b_neg_s) & (is_mul_s | ~rt_zero_s);
                        neg_rem_d = is_div_s & a_neg_s;
                    end else if (func == FN_MTHI) begin
                        hi_d = rs_val;
                    end else if (func == FN_MTLO) begin
                        lo_d = rs_val;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = FIX;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = fix_hi_s;
                    lo_d   = fix_lo_s;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign stall = start & busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: table of MULT/DIV vectors issued
// back-to-back through a scoreboard queue, plus hand-written sequences for
// MTHI/MTLO, stall, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    func;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          flush;
    logic          busy;
    logic          stall;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]   fn;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           idx;
    } sb_t;

    vec_t vecs[14];
    sb_t  sb_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func   (func),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request for exactly one accepting edge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        func   = f;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
    endtask

    // Issue a table vector, then wait for its completion and score it.
    task automatic run_vec(input int i);
        sb_t e;
        sb_t got;
        int  n;
        e.exp_hi = vecs[i].exp_hi;
        e.exp_lo = vecs[i].exp_lo;
        e.idx    = i;
        sb_q.push_back(e);
        issue(vecs[i].fn, vecs[i].rs, vecs[i].rt);
        check($sformatf("v%0d busy_after_accept", i), {63'd0, busy}, 64'd1);
        check($sformatf("v%0d done_low_while_busy", i), {63'd0, done}, 64'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check($sformatf("v%0d busy_cycles", i), 64'(n), 64'(LAT));
        check($sformatf("v%0d done_pulse", i), {63'd0, done}, 64'd1);
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", i), 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check($sformatf("v%0d hi", got.idx), {32'd0, hi}, {32'd0, got.exp_hi});
            check($sformatf("v%0d lo", got.idx), {32'd0, lo}, {32'd0, got.exp_lo});
        end
    endtask

    initial begin
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        int           n;
        int           seen_done;

        vecs[0]  = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{FN_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{FN_MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
        vecs[3]  = '{FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{FN_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[5]  = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{FN_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[7]  = '{FN_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8]  = '{FN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{FN_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[11] = '{FN_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[12] = '{FN_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[13] = '{FN_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

        rst    = 1'b1;
        start  = 1'b0;
        func   = 6'd0;
        rs_val = '0;
        rt_val = '0;
        flush  = 1'b0;
        tick();
        tick();
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick();

        // Vectors issued back-to-back: each new request lands in the done cycle.
        for (int i = 0; i < 14; i++) begin
            run_vec(i);
        end
        tick();
        check("done one cycle only", {63'd0, done}, 64'd0);

        // MTHI / MTLO single-cycle writes.
        hold_lo = lo;
        issue(FN_MTHI, 32'h0000_1234, 32'h0);
        check("mthi hi", {32'd0, hi}, 64'h1234);
        check("mthi lo kept", {32'd0, lo}, {32'd0, hold_lo});
        check("mthi busy", {63'd0, busy}, 64'd0);
        issue(FN_MTLO, 32'h0000_5678, 32'h0);
        check("mtlo lo", {32'd0, lo}, 64'h5678);
        check("mtlo hi kept", {32'd0, hi}, 64'h1234);

        // Unknown function code and flushed request are both dropped.
        issue(FN_MFHI, 32'hDEAD_BEEF, 32'h1);
        check("ignored func busy", {63'd0, busy}, 64'd0);
        check("ignored func hi", {32'd0, hi}, 64'h1234);
        flush = 1'b1;
        issue(FN_MTHI, 32'hBAD0_BAD0, 32'h0);
        flush = 1'b0;
        check("flush drops mthi", {32'd0, hi}, 64'h1234);
        flush = 1'b1;
        issue(FN_DIV, 32'h10, 32'h2);
        flush = 1'b0;
        check("flush drops div", {63'd0, busy}, 64'd0);

        // Flush in ITER cycle 10, with a stalled request along the way.
        issue(FN_MTHI, 32'h0000_AAAA, 32'h0);
        hold_lo = lo;
        issue(FN_DIV, 32'h0000_0100, 32'h0000_0003);
        for (int k = 1; k < 10; k++) begin
            tick();
        end
        start  = 1'b1;
        func   = FN_MTLO;
        rs_val = 32'h0000_5555;
        #1;
        check("stall while busy", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush busy low", {63'd0, busy}, 64'd0);
        check("stalled mtlo ignored", {32'd0, lo}, {32'd0, hold_lo});
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen_done = 1;
            tick();
        end
        check("flush no done", 64'(seen_done), 64'd0);
        check("flush hi kept", {32'd0, hi}, 64'hAAAA);
        check("flush lo kept", {32'd0, lo}, {32'd0, hold_lo});

        // Flush in the FIX cycle suppresses the commit.
        issue(FN_MULTU, 32'h0000_0010, 32'h0000_0010);
        for (int k = 1; k < LAT; k++) begin
            tick();
        end
        check("fix still busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fix flush no done", {63'd0, done}, 64'd0);
        check("fix flush busy", {63'd0, busy}, 64'd0);
        check("fix flush hi kept", {32'd0, hi}, 64'hAAAA);

        // Asynchronous reset in the middle of a multiply, away from any edge.
        issue(FN_MULTU, 32'hFFFF_0000, 32'h0000_FFFF);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst hi", {32'd0, hi}, 64'd0);
        check("async rst lo", {32'd0, lo}, 64'd0);
        check("async rst busy", {63'd0, busy}, 64'd0);
        #1;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy || done) n++;
        end
        check("idle after rst", 64'(n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
